// File: rtl/match_ctrl_pkg.sv
// Shared encodings and default timing for the match controller.
package match_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_MATCH_END = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  localparam int DEF_WIN_SCORE    = 7;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_PAUSE_FRAMES = 90;

  function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
    return (val >= lim) ? lim : val + 4'd1;
  endfunction

endpackage

// File: rtl/match_ctrl_btn_sync.sv
// Two-flop synchroniser for the raw start button plus a rising-edge pulse.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_rise
);

  logic [1:0] sync_reg;
  logic       prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], btn_raw};
      prev_reg <= sync_reg[1];
    end
  end

  assign btn_rise = sync_reg[1] & ~prev_reg;

endmodule

// File: rtl/match_ctrl.sv
// Match sequencing: serve countdown, rally gating of physics, point pause and scoring.
module match_ctrl
  import match_ctrl_pkg::*;
#(
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int PAUSE_FRAMES = DEF_PAUSE_FRAMES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       game_over,
  input  logic [1:0] winner,
  input  logic       valid,
  output logic       phys_en,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [2:0] state,
  output logic [1:0] last_winner,
  output logic       match_over,
  output logic [1:0] match_winner,
  output logic       point_flash
);

  localparam logic [3:0] WIN_L   = WIN_SCORE[3:0];
  localparam logic [7:0] SERVE_L = SERVE_FRAMES[7:0];
  localparam logic [7:0] PAUSE_L = PAUSE_FRAMES[7:0];

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [3:0] p1_reg, p1_next;
  logic [3:0] p2_reg, p2_next;
  logic [1:0] last_reg, last_next;
  logic       start_pulse;
  logic       point_event;

  btn_sync u_btn_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (start_btn),
    .btn_rise (start_pulse)
  );

  assign point_event = valid && game_over &&
                       (winner == WIN_P1 || winner == WIN_P2) &&
                       (state_reg == ST_PLAY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 8'd0;
      p1_reg    <= 4'd0;
      p2_reg    <= 4'd0;
      last_reg  <= WIN_NONE;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      p1_reg    <= p1_next;
      p2_reg    <= p2_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    p1_next      = p1_reg;
    p2_next      = p2_reg;
    last_next    = last_reg;
    phys_en      = 1'b0;
    match_over   = 1'b0;
    match_winner = WIN_NONE;
    point_flash  = 1'b0;

    case (state_reg)
      ST_IDLE, ST_MATCH_END: begin
        if (state_reg == ST_MATCH_END) begin
          match_over   = 1'b1;
          match_winner = (p1_reg == WIN_L) ? WIN_P1 : WIN_P2;
        end
        if (start_pulse) begin
          p1_next    = 4'd0;
          p2_next    = 4'd0;
          last_next  = WIN_NONE;
          cnt_next   = SERVE_L;
          state_next = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          // Leave on the 1 -> 0 tick so the counter never wraps.
          if (cnt_reg <= 8'd1) begin
            cnt_next   = 8'd0;
            state_next = ST_PLAY;
          end else begin
            cnt_next = cnt_reg - 8'd1;
          end
        end
      end
      ST_PLAY: begin
        phys_en = frame_tick;
        if (point_event) begin
          if (winner == WIN_P1) p1_next = sat_inc(p1_reg, WIN_L);
          else                  p2_next = sat_inc(p2_reg, WIN_L);
          last_next  = winner;
          cnt_next   = PAUSE_L;
          state_next = ST_POINT;
        end
      end
      ST_POINT: begin
        point_flash = 1'b1;
        if (frame_tick) begin
          if (cnt_reg <= 8'd1) begin
            if (p1_reg == WIN_L || p2_reg == WIN_L) begin
              cnt_next   = 8'd0;
              state_next = ST_MATCH_END;
            end else begin
              cnt_next   = SERVE_L;
              state_next = ST_SERVE;
            end
          end else begin
            cnt_next = cnt_reg - 8'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign state       = state_reg;
  assign p1_score    = p1_reg;
  assign p2_score    = p2_reg;
  assign last_winner = last_reg;

endmodule

// File: tb/tb_match_ctrl.sv
// Randomised and directed bench for match_ctrl against a behavioural match model.
module tb_match_ctrl;

  localparam int W  = 2;
  localparam int SF = 60;
  localparam int PF = 90;

  localparam int PH_IDLE = 0, PH_SERVE = 1, PH_PLAY = 2, PH_POINT = 3, PH_END = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       game_over = 1'b0;
  logic       valid = 1'b0;
  logic [1:0] winner = 2'd0;
  logic       phys_en;
  logic [3:0] p1_score, p2_score;
  logic [2:0] state;
  logic [1:0] last_winner, match_winner;
  logic       match_over, point_flash;

  int checks = 0;
  int failures = 0;
  int serve_ticks = 0;
  int point_ticks = 0;

  // Behavioural model of the match
  int m_ph, m_cnt, m_p1, m_p2, m_last;
  int btn_hist [3];

  always #5 clk = ~clk;

  match_ctrl #(
    .WIN_SCORE    (W),
    .SERVE_FRAMES (SF),
    .PAUSE_FRAMES (PF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .start_btn    (start_btn),
    .game_over    (game_over),
    .winner       (winner),
    .valid        (valid),
    .phys_en      (phys_en),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .state        (state),
    .last_winner  (last_winner),
    .match_over   (match_over),
    .match_winner (match_winner),
    .point_flash  (point_flash)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ph = PH_IDLE; m_cnt = 0; m_p1 = 0; m_p2 = 0; m_last = 0;
    for (int i = 0; i < 3; i++) btn_hist[i] = 0;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit pulse, pev;
    pulse = (btn_hist[1] != 0) && (btn_hist[2] == 0);
    pev = valid && game_over && (winner == 2'd1 || winner == 2'd2) && (m_ph == PH_PLAY);
    case (m_ph)
      PH_IDLE, PH_END: if (pulse) begin
        m_p1 = 0; m_p2 = 0; m_last = 0; m_cnt = SF; m_ph = PH_SERVE;
        $display("start match t=%0t", $time);
      end
      PH_SERVE: if (frame_tick) begin
        m_cnt--;
        if (m_cnt == 0) m_ph = PH_PLAY;
      end
      PH_PLAY: if (pev) begin
        if (winner == 2'd1) m_p1 = (m_p1 + 1 > W) ? W : m_p1 + 1;
        else                m_p2 = (m_p2 + 1 > W) ? W : m_p2 + 1;
        m_last = int'(winner);
        m_cnt = PF;
        m_ph = PH_POINT;
        $display("point winner=%0d p1=%0d p2=%0d t=%0t", m_last, m_p1, m_p2, $time);
      end
      PH_POINT: if (frame_tick) begin
        m_cnt--;
        if (m_cnt == 0) begin
          if (m_p1 == W || m_p2 == W) m_ph = PH_END;
          else begin m_cnt = SF; m_ph = PH_SERVE; end
        end
      end
      default: m_ph = PH_IDLE;
    endcase
    btn_hist[2] = btn_hist[1];
    btn_hist[1] = btn_hist[0];
    btn_hist[0] = int'(start_btn);
  endtask

  task automatic compare_all();
    chk("state", state, m_ph);
    chk("p1_score", p1_score, m_p1);
    chk("p2_score", p2_score, m_p2);
    chk("last_winner", last_winner, m_last);
    chk("phys_en", phys_en, (m_ph == PH_PLAY && frame_tick) ? 1 : 0);
    chk("match_over", match_over, (m_ph == PH_END) ? 1 : 0);
    chk("match_winner", match_winner, (m_ph == PH_END) ? ((m_p1 == W) ? 1 : 2) : 0);
    chk("point_flash", point_flash, (m_ph == PH_POINT) ? 1 : 0);
    if (state == 3'd1 && frame_tick) serve_ticks++;
    if (state == 3'd3 && frame_tick) point_ticks++;
  endtask

  // One clock: drive inputs, check at the falling edge, step the model at the rising edge.
  task automatic cyc(input bit tk, input bit bt, input bit v, input bit go, input int w);
    frame_tick = tk; start_btn = bt; valid = v; game_over = go; winner = w[1:0];
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_until(input int target, input int maxc);
    int n = 0;
    bit t = 1'b0;
    while (m_ph != target && n < maxc) begin
      t = ~t;
      cyc(t, 0, 0, 0, 0);
      n++;
    end
    if (m_ph != target) chk("timeout_reaching_state", m_ph, target);
  endtask

  task automatic press_start();
    repeat (3) cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic score_point(input int w);
    run_until(PH_PLAY, 400);
    cyc(1, 0, 1, 1, w);
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    compare_all();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Serve countdown: exactly SF ticks in SERVE before PLAY
    repeat (4) cyc(1, 0, 0, 0, 0);
    serve_ticks = 0;
    press_start();
    run_until(PH_PLAY, 400);
    chk("serve_ticks", serve_ticks, SF);
    repeat (4) cyc(1, 0, 0, 0, 0);

    // Invalid winner and start presses are ignored in PLAY
    cyc(1, 0, 1, 1, 3);
    cyc(0, 0, 1, 1, 0);
    press_start();
    chk("play_after_ignored", state, PH_PLAY);
    chk("score_after_invalid", p1_score + p2_score, 0);

    // game_over held across three strobes scores once
    cyc(0, 0, 1, 1, 2);
    point_ticks = 0;
    cyc(1, 0, 0, 1, 2);
    cyc(0, 0, 1, 1, 2);
    cyc(1, 0, 0, 1, 2);
    cyc(0, 0, 1, 1, 2);
    chk("p2_single_point", p2_score, 1);
    chk("last_winner_p2", last_winner, 2);
    run_until(PH_SERVE, 400);
    chk("point_ticks", point_ticks, PF);

    // P1 takes two points: match ends with P1 as winner
    score_point(1);
    score_point(1);
    run_until(PH_END, 400);
    chk("match_over_end", match_over, 1);
    chk("match_winner_p1", match_winner, 1);
    press_start();
    chk("restart_state", state, PH_SERVE);
    chk("restart_scores", p1_score + p2_score, 0);

    // Random traffic
    begin
      bit btn = 1'b0;
      for (int i = 0; i < 12000; i++) begin
        if ($urandom_range(0, 99) == 0) btn = ~btn;
        cyc(1'($urandom_range(0, 1)), btn, $urandom_range(0, 5) == 0,
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end
      repeat (6) cyc(0, 0, 0, 0, 0);
    end

    // Asynchronous reset in the middle of a point pause
    if (m_ph == PH_IDLE || m_ph == PH_END) press_start();
    score_point(2);
    repeat (10) cyc(1, 0, 0, 0, 0);
    chk("in_point_before_reset", state, PH_POINT);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) cyc(1, 0, 0, 0, 0);
    press_start();
    run_until(PH_PLAY, 400);
    chk("play_after_reset", state, PH_PLAY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
